display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_if.sv | 22 ++
 rtl/display_scan.sv | 92 +++++++++
 2 files changed

// File: rtl/display_scan_if.sv
// Digit-data, enable and display-drive bundle for the multiplexed 7-segment scanner.
// The counter side is the master; display_scan is the slave.
interface display_scan_if;
    logic [3:0] Qdata3_in;
    logic [3:0] Qdata2_in;
    logic [3:0] Qdata1_in;
    logic [3:0] Qdata0_in;
    logic       ena_disp;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       frame_out;

    modport master (
        output Qdata3_in, Qdata2_in, Qdata1_in, Qdata0_in, ena_disp,
        input  seg_out, an_out, frame_out
    );

    modport slave (
        input  Qdata3_in, Qdata2_in, Qdata1_in, Qdata0_in, ena_disp,
        output seg_out, an_out, frame_out
    );
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame snapshot and inter-digit blanking.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic         clk_disp,
    input  logic         rst_disp,
    display_scan_if.slave disp
);

    typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} idx_t;

    localparam logic [15:0] TICK_VAL  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLANK_VAL = 16'(BLANK_CYC);

    logic [15:0] cnt_q, cnt_d;
    idx_t        idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_q, frame_d;
    logic        tick, adv;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] snap, input logic [1:0] n);
`ifdef LEADING_ZERO_BLANK_EN
        // Digit n is a leading zero when it and every more-significant digit are zero.
        logic [15:0] upper;
        upper = snap >> {n, 2'b00};
        if ((n != 2'd0) && (upper == 16'd0)) return 7'b1111111;
`endif
        return bcd_to_seg(snap[{n, 2'b00} +: 4]);
    endfunction

    always_comb begin
        tick    = (cnt_q == TICK_VAL);
        adv     = disp.ena_disp && tick;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        if (disp.ena_disp) cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (adv) idx_d = idx_t'(idx_q + 2'd1);
        frame_d = adv && (idx_q == DIG3);
        if (frame_d) snap_d = {disp.Qdata3_in, disp.Qdata2_in, disp.Qdata1_in, disp.Qdata0_in};
        // Segments and anode are both derived from next-state so they switch on the same edge.
        seg_d   = digit_seg(snap_d, idx_d);
        an_d    = 4'b1111;
        if (cnt_d >= BLANK_VAL) an_d[idx_d] = 1'b0;
    end

    always_ff @(posedge clk_disp or negedge rst_disp) begin
        if (!rst_disp) begin
            cnt_q   <= 16'd0;
            idx_q   <= DIG0;
            snap_q  <= 16'd0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    // Disable darkens the anodes at once; the held anode state returns unchanged on resume.
    assign disp.an_out    = an_q | {4{~disp.ena_disp}};
    assign disp.seg_out   = seg_q;
    assign disp.frame_out = frame_q;

endmodule
